// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op codes, FSM
// state encoding and default busy-cycle counts.
package md_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_MADD  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2
  } md_state_e;

  localparam int MUL_CYC_DEF = 5;
  localparam int DIV_CYC_DEF = 10;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/md_counter.sv
// Loadable down-counter for the MD busy period. o_done flags the last
// busy cycle (count == 1); the counter parks at zero when idle.
module md_counter
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Load on issue, otherwise count down to zero and hold.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == CNT_W'(1));

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, sequences multi-cycle
// MULT/MULTU/DIV/DIVU, performs MTHI/MTLO and raises the D-stage stall.
// Optional feature macro: MD_MADD_EN (op 111 = signed multiply-accumulate).
module md_sched
  import md_pkg::*;
#(
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e r_state;
  md_state_e w_state_nxt;
  md_op_e    w_op;

  logic        w_idle;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_accept_mul;
  logic        w_accept_div;
  logic        w_load;
  logic        w_done;
  logic [CNT_W-1:0] w_load_val;

  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic               w_div_zero;

  logic [31:0] w_pend_hi_nxt;
  logic [31:0] w_pend_lo_nxt;
  logic        w_pend_wr_nxt;

  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_wr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  assign w_op   = md_op_e'(op);
  assign w_idle = (r_state == ST_IDLE);

  // Classify the issuing op into multiply-class and divide-class.
  always_comb begin
    w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
`ifdef MD_MADD_EN
    if (w_op == OP_MADD) w_is_mul = 1'b1;
`endif
    w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  end

  // Starts are only honoured in IDLE; a start during BUSY is dropped.
  assign w_accept_mul = w_idle && start && w_is_mul;
  assign w_accept_div = w_idle && start && w_is_div;
  assign w_load       = w_accept_mul || w_accept_div;
  assign w_load_val   = w_accept_div ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);

  md_counter u_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Next-state logic: leave IDLE on an accepted op, return on the last busy cycle.
  always_comb begin
    // NOTE: defaulting every combinational output first keeps the block
    // latch-free no matter which branches are taken.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_mul)      w_state_nxt = ST_MUL_BUSY;
        else if (w_accept_div) w_state_nxt = ST_DIV_BUSY;
      end
      ST_MUL_BUSY, ST_DIV_BUSY: begin
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Products from sign- or zero-extended operands; low 64 bits are exact.
  assign w_prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u   = {32'b0, a} * {32'b0, b};
  // SV signed division truncates toward zero; remainder follows dividend.
  assign w_sq       = $signed(a) / $signed(b);
  assign w_sr       = $signed(a) % $signed(b);
  assign w_div_zero = (b == 32'b0);

  // Select the result captured into the pending registers at issue.
  always_comb begin
    w_pend_hi_nxt = '0;
    w_pend_lo_nxt = '0;
    w_pend_wr_nxt = 1'b0;
    case (w_op)
      OP_MULT: begin
        {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
        w_pend_wr_nxt = 1'b1;
      end
      OP_MULTU: begin
        {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
        w_pend_wr_nxt = 1'b1;
      end
      OP_DIV: begin
        w_pend_lo_nxt = w_sq;
        w_pend_hi_nxt = w_sr;
        // A zero divisor still runs the full period but commits nothing.
        w_pend_wr_nxt = !w_div_zero;
      end
      OP_DIVU: begin
        w_pend_lo_nxt = a / b;
        w_pend_hi_nxt = a % b;
        w_pend_wr_nxt = !w_div_zero;
      end
`ifdef MD_MADD_EN
      OP_MADD: begin
        // Accumulate base is HI/LO as they stand at the issue edge.
        {w_pend_hi_nxt, w_pend_lo_nxt} = {r_hi, r_lo} + w_prod_s;
        w_pend_wr_nxt = 1'b1;
      end
`endif
      default: begin
        w_pend_wr_nxt = 1'b0;
      end
    endcase
  end

  // Pending result registers, captured when a multi-cycle op is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else if (w_load) begin
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_wr <= w_pend_wr_nxt;
    end
  end

  // Committed HI/LO: pending commit on the last busy cycle, MTHI/MTLO in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!w_idle) begin
      if (w_done && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (start) begin
      if (w_op == OP_MTHI) r_hi <= a;
      if (w_op == OP_MTLO) r_lo <= a;
    end
  end

  assign busy     = !w_idle;
  assign stall_md = d_is_md && (busy || (start && (w_is_mul || w_is_div)));
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: a per-cycle compare against a
// behavioural HI/LO model plus directed literal expectations.
// Honours MD_MADD_EN in the same way as the design.
module tb_md_sched;
  import md_pkg::*;

  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 10;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        start   = 1'b0;
  logic [2:0]  op      = 3'd0;
  logic [31:0] a       = '0;
  logic [31:0] b       = '0;
  logic        d_is_md = 1'b0;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  md_sched #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_left = 0;
  bit          m_commit = 1'b0;

  function automatic bit is_long(input logic [2:0] o);
    bit r;
    r = (o >= 3'd1) && (o <= 3'd4);
`ifdef MD_MADD_EN
    if (o == 3'd7) r = 1'b1;
`endif
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_commit = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_commit) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start) begin
      case (op)
        3'd1: begin
          p = 64'(longint'(sa) * longint'(sb));
          {m_phi, m_plo} = p; m_commit = 1'b1; m_left = MUL_CYC;
        end
        3'd2: begin
          p = 64'(a) * 64'(b);
          {m_phi, m_plo} = p; m_commit = 1'b1; m_left = MUL_CYC;
        end
        3'd3: begin
          m_commit = (b != 0);
          if (b != 0) begin m_plo = sa / sb; m_phi = sa % sb; end
          m_left = DIV_CYC;
        end
        3'd4: begin
          m_commit = (b != 0);
          if (b != 0) begin m_plo = a / b; m_phi = a % b; end
          m_left = DIV_CYC;
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
`ifdef MD_MADD_EN
        3'd7: begin
          p = {m_hi, m_lo} + 64'(longint'(sa) * longint'(sb));
          {m_phi, m_plo} = p; m_commit = 1'b1; m_left = MUL_CYC;
        end
`endif
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, m_left != 0});
      check("stall_md", {31'b0, stall_md},
            {31'b0, d_is_md && ((m_left != 0) || (start && is_long(op)))});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step(1);
    start = 1'b0; op = 3'd0;
  endtask

  // Counts busy cycles until busy drops; returns just after a negedge.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] x);
    do_op(o, x, 32'd0);
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n;
    step(2);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall_md}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    chk_en = 1'b1;
    #1 reset = 1'b1;

    // MULT -3 * 4
    do_op(3'd1, 32'hFFFF_FFFD, 32'd4);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF4);

    // MULTU back-to-back in the first non-busy cycle
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIV 7 / -2
    do_op(3'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    check("divneg_lo", lo, 32'hFFFF_FFFD);
    check("divneg_hi", hi, 32'h0000_0001);

    // MTHI / MTLO, then DIVU by zero keeps them
    mt(3'd5, 32'h11);
    mt(3'd6, 32'h22);
    check("mt_hi", hi, 32'h11);
    check("mt_lo", lo, 32'h22);
    do_op(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    check("divz_cycles", n, 32'd10);
    check("divz_hi", hi, 32'h11);
    check("divz_lo", lo, 32'h22);

    // Stall during DIV with D holding an MD op; MTHI while busy is dropped
    d_is_md = 1'b1;
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    #1 check("stall_issue", {31'b0, stall_md}, 32'd1);
    step(1);
    start = 1'b0; op = 3'd0;
    step(1);
    start = 1'b1; op = 3'd5; a = 32'h55;
    step(1);
    start = 1'b0; op = 3'd0;
    wait_idle(n);
    check("stall_div_cycles", n, 32'd8);
    check("stall_drop", {31'b0, stall_md}, 32'd0);
    check("stall_div_hi", hi, 32'd2);
    check("stall_div_lo", lo, 32'd14);
    d_is_md = 1'b0;

    // Reset in the third busy cycle of DIV, then MTLO
    do_op(3'd3, 32'd50, 32'd5);
    step(2);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    #1;
    mt(3'd6, 32'h1234);
    check("post_rst_lo", lo, 32'h1234);

`ifdef MD_MADD_EN
    mt(3'd5, 32'h0);
    mt(3'd6, 32'hFFFF_FFFF);
    do_op(3'd7, 32'd1, 32'd1);
    wait_idle(n);
    check("madd_cycles", n, 32'd5);
    check("madd_hi", hi, 32'h0000_0001);
    check("madd_lo", lo, 32'h0000_0000);
`else
    mt(3'd5, 32'h77);
    mt(3'd6, 32'h88);
    do_op(3'd7, 32'd5, 32'd6);
    @(negedge clk);
    check("op7_busy", {31'b0, busy}, 32'd0);
    check("op7_hi", hi, 32'h77);
    check("op7_lo", lo, 32'h88);
    #1;
`endif

    step(3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the five-stage pipeline. It owns the HI/LO register pair and sequences multi-cycle MULT/MULTU/DIV/DIVU operations issued from the E stage. It also performs the single-cycle MTHI/MTLO writes. It produces `busy` and a D-stage stall request that the hazard unit ORs into its existing stall signal.

## Interface
- `MUL_CYC`, default 5: busy cycles for MULT/MULTU (and MADD).
- `DIV_CYC`, default 10: busy cycles for DIV/DIVU.
- `clk  in  1`: clock; all state changes on the rising edge.
- `reset  in  1`: synchronous, active-low; sampled on the `clk` rising edge.
- `start  in  1`: E-stage instruction is an MD operation; qualified by `op`.
- `op  in  3`: operation code from md_pkg.
- `a  in  32`: forwarded rs value (E stage).
- `b  in  32`: forwarded rt value (E stage).
- `d_is_md  in  1`: D-stage instruction reads or writes HI/LO (mult/div/mthi/mtlo/mfhi/mflo/madd).
- `busy  out  1`: multi-cycle operation in progress.
- `stall_md  out  1`: D-stage stall request, combinational.
- `hi  out  32`: committed HI.
- `lo  out  32`: committed LO.

## Operation
- Op codes:
  - 000 NONE
  - 001 MULT
  - 010 MULTU
  - 011 DIV
  - 100 DIVU
  - 101 MTHI
  - 110 MTLO
  - 111 MADD (see Configuration)
- States: IDLE, MUL_BUSY, DIV_BUSY.
- IDLE with `start`=1:
  - MULT/MULTU → MUL_BUSY; counter loaded with `MUL_CYC`; the 64-bit product (signed or unsigned) is captured into pending regs.
  - DIV/DIVU → DIV_BUSY; counter loaded with `DIV_CYC`; quotient goes to pending LO, remainder to pending HI.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - MTHI/MTLO: `hi`/`lo` ← `a` at that edge; state stays IDLE.
  - NONE: no effect.
- In a BUSY state the counter decrements each edge. On the edge where counter==1:
  - pending HI/LO commit to `hi`/`lo`;
  - state → IDLE.
- Division by zero: the full `DIV_CYC` busy period still runs; `hi`/`lo` keep their prior values at commit.
- `start` in a BUSY state is ignored, including MTHI/MTLO; the hazard unit must prevent this.
- `stall_md` = `d_is_md` & (`busy` | (`start` & op ∈ {MULT, MULTU, DIV, DIVU, MADD})).
- MFHI/MFLO read `hi`/`lo` directly. `stall_md` guarantees they never read mid-operation.
- Reset (`reset`=0 at an edge):
  - state → IDLE, counter → 0, `hi` → 0, `lo` → 0, pending regs → 0;
  - aborts any in-flight operation.

## Timing
- Reset values: `busy`=0, `stall_md`=0 (given `d_is_md`=0), `hi`=0, `lo`=0.
- A MULT/MULTU started at edge k:
  - `busy`=1 in the cycles after edges k … k+4;
  - result visible and `busy`=0 after edge k+5.
  - In general, latency equals `MUL_CYC`.
- DIV/DIVU follow the same pattern with `DIV_CYC`.
- MTHI/MTLO: new value visible the cycle after the start edge; no busy cycle.
- Back-to-back: a new `start` is accepted in the first cycle with `busy`=0.
- `stall_md` asserts combinationally in the issue cycle when D already holds an MD instruction.

## Configuration
- `MD_MADD_EN` defined:
  - op 111 = MADD; {HI,LO} ← {HI,LO} + signed(a)×signed(b);
  - runs `MUL_CYC` busy cycles;
  - the accumulate base is HI/LO sampled at the start edge.
- `MD_MADD_EN` undefined: op 111 is treated as NONE and never sets `busy`.

## Structure
- Shared package md_pkg holds:
  - op code constants;
  - state encoding;
  - default `MUL_CYC` and `DIV_CYC`.
- One sub-module, md_counter: loadable down-counter with a `done` output (count==1). It is instantiated once, and the load value is muxed by op class.
- Arithmetic stays inline in md_sched.

## Test plan
- MULT a=0xFFFFFFFD, b=4 → `busy` high exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF4.
- MULTU a=0xFFFFFFFF, b=2 → `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 cycles; DIV a=0xFFFFFFF9 (−7), b=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=7, b=0 with prior `hi`=0x11, `lo`=0x22 → 10 busy cycles, `hi`/`lo` unchanged.
- `d_is_md`=1 during DIV busy → `stall_md`=1 every busy cycle, 0 the cycle `busy` drops; MTHI a=0x55 issued while busy → `hi` unchanged.
- `reset`=0 on the third cycle of DIV → next cycle `busy`=0, `hi`=`lo`=0; a following MTLO a=0x1234 → `lo`=0x1234 one cycle later.
- With `MD_MADD_EN`: `hi`=0, `lo`=0xFFFFFFFF, MADD a=1, b=1 → `hi`=0x00000001, `lo`=0x00000000 after 5 cycles. Without the macro: op 111 leaves `busy`=0 and `hi`/`lo` unchanged.
